lut_exerciser: RTL and testbench

Self-checking stimulus generator for the hx1k board's external LUT experiments. It drives the two LUT input pins through all four input combinations and waits a programmable settle time after each. It then samples the LUT result returned on a pin and compares it against an expected truth table. Pass/fail and per-vector mismatch flags are reported for LEDs or downstream logic. It sits on the opposite side of the pins from the LUT under test: it drives A and B and receives Y.

---
 rtl/lut_exerciser.sv | 128 ++++++++++++
 tb/tb_lut_exerciser.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_exerciser.sv
// Drives a 2-input external LUT through {B,A} = 00..11, lets each vector settle,
// samples the synchronized result and compares it against an expected truth table.
//
// state    | meaning
// IDLE     | waiting for START after reset
// SETTLE   | holding the current vector while the pin round-trip settles
// SAMPLE   | recording the mismatch flag for the current vector
// DONE     | result valid, waiting for START to rerun
module lut_exerciser #(
  parameter int          SETTLE_CYCLES = 12,
  parameter logic [3:0]  EXPECT        = 4'b1000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       START,
  input  logic       Y_IN,
  output logic       A_OUT,
  output logic       B_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_VEC
);

  // Below 3 cycles the synchronizer would eat the whole settle window.
  localparam int S_EFF = (SETTLE_CYCLES < 3) ? 3 : SETTLE_CYCLES;
  localparam int CW    = $clog2(S_EFF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(S_EFF - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ab_q, ab_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [3:0]    fail_q, fail_d;
  logic          y_meta_q, y_meta_d;
  logic          y_sync_q, y_sync_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ab_d     = ab_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    y_meta_d = Y_IN;
    y_sync_d = y_meta_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          idx_d   = 2'd0;
          ab_d    = 2'b00;
          cnt_d   = '0;
          fail_d  = 4'b0000;
          pass_d  = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        fail_d[idx_q] = (y_sync_q != EXPECT[idx_q]);
        if (idx_q == 2'd3) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ab_d    = 2'b00;
          // Includes the flag being written for the last vector this cycle.
          pass_d  = (fail_d == 4'b0000);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          ab_d    = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      ab_q     <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 4'b0000;
      y_meta_q <= 1'b0;
      y_sync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ab_q     <= ab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      y_meta_q <= y_meta_d;
      y_sync_q <= y_sync_d;
    end
  end

  assign A_OUT    = ab_q[0];
  assign B_OUT    = ab_q[1];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign FAIL_VEC = fail_q;

endmodule

// File: tb/tb_lut_exerciser.sv
// Bench for lut_exerciser: two instances (default, and clamped settle with another
// truth table) against a cycle-level behavioural model of run timing and results.
module tb_lut_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode  = 3;        // 0 AND, 1 OR, 2 stuck-0, 3 random toggling
  logic y_rand = 1'b0;
  logic [1:0] y0_pipe = 2'b00;
  logic y_in0, y_in1;

  logic a0, b0, busy0, done0, pass0;
  logic a1, b1, busy1, done1, pass1;
  logic [3:0] fv0, fv1;

  int compared   = 0;
  int mismatched = 0;
  logic chk_en   = 1'b0;

  function automatic logic lut(input int m, input logic [1:0] v);
    case (m)
      0:       return v[1] & v[0];
      1:       return v[1] | v[0];
      default: return 1'b0;
    endcase
  endfunction

  // dut0 sees a LUT with a 2-cycle pin round-trip, dut1 a zero-delay one.
  always @(posedge clk) begin
    y_rand  <= 1'($urandom);
    y0_pipe <= {y0_pipe[0], lut(mode, {b0, a0})};
  end
  assign y_in0 = (mode == 3) ? y_rand : y0_pipe[1];
  assign y_in1 = (mode == 3) ? y_rand : lut(mode, {b1, a1});

  lut_exerciser dut0 (
    .CLK(clk), .RESETN(rst_n), .START(start), .Y_IN(y_in0),
    .A_OUT(a0), .B_OUT(b0), .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_VEC(fv0)
  );

  lut_exerciser #(.SETTLE_CYCLES(2), .EXPECT(4'b1110)) dut1 (
    .CLK(clk), .RESETN(rst_n), .START(start), .Y_IN(y_in1),
    .A_OUT(a1), .B_OUT(b1), .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_VEC(fv1)
  );

  // Model: phase 0 idle, 1 running (t = cycles since start edge), 2 done.
  localparam logic [3:0] EXP [2] = '{4'b1000, 4'b1110};
  localparam int         SC  [2] = '{12, 3};
  int         phase [2] = '{0, 0};
  int         t     [2] = '{0, 0};
  logic [3:0] efail [2] = '{4'b0000, 4'b0000};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        phase[k] = 0;
        t[k]     = 0;
      end else if (phase[k] != 1 && start) begin
        phase[k] = 1;
        t[k]     = 0;
        for (int v = 0; v < 4; v++)
          efail[k][v] = (lut(mode, 2'(v)) != EXP[k][v]);
      end else if (phase[k] == 1) begin
        t[k]++;
        if (t[k] == 4 * (SC[k] + 1)) phase[k] = 2;
      end
    end
  end

  // {BUSY, DONE, PASS, B, A, FAIL_VEC}
  function automatic logic [8:0] model_out(input int k);
    int n;
    logic [3:0] m;
    logic [1:0] ab;
    m  = 4'b0000;
    ab = 2'b00;
    if (phase[k] == 1) begin
      n  = t[k] / (SC[k] + 1);
      ab = 2'(n);
    end else begin
      n = (phase[k] == 2) ? 4 : 0;
    end
    for (int v = 0; v < 4; v++)
      if (v < n) m[v] = efail[k][v];
    return {phase[k] == 1, phase[k] == 2, (phase[k] == 2) && (efail[k] == 4'b0000), ab, m};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [8:0] act, exp_v;
        act   = (k == 0) ? {busy0, done0, pass0, b0, a0, fv0}
                         : {busy1, done1, pass1, b1, a1, fv1};
        exp_v = model_out(k);
        compared++;
        if (act !== exp_v) begin
          mismatched++;
          $display("FAIL cycle_check dut%0d at %0t: got %b want %b (busy,done,pass,b,a,fail_vec)",
                   k, $time, act, exp_v);
        end
      end
    end
  end

  int busy_cnt0 = 0;
  int busy_cnt1 = 0;
  always @(negedge clk) begin
    if (busy0 === 1'b1) busy_cnt0++;
    if (busy1 === 1'b1) busy_cnt1++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    repeat (len) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!(done0 === 1'b1 && done1 === 1'b1) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!(done0 === 1'b1 && done1 === 1'b1)) begin
      compared++;
      mismatched++;
      $display("FAIL wait_done: DONE not seen within %0d cycles (done0=%b done1=%b)", maxc, done0, done1);
    end
  endtask

  initial begin
    int dcnt;
    // Reset with START high and Y toggling.
    rst_n = 1'b0;
    start = 1'b1;
    mode  = 3;
    repeat (2) @(negedge clk);
    check("reset_dut0", {busy0, done0, pass0, b0, a0, fv0}, 0);
    check("reset_dut1", {busy1, done1, pass1, b1, a1, fv1}, 0);
    chk_en = 1'b1;
    start  = 1'b0;
    mode   = 0;
    rst_n  = 1'b1;
    repeat (3) @(negedge clk);

    // AND model
    busy_cnt0 = 0;
    busy_cnt1 = 0;
    pulse_start(1);
    wait_done(200);
    check("and_fail_vec", fv0, 4'b0000);
    check("and_pass", pass0, 1);
    check("and_busy_len", busy_cnt0, 52);
    check("clamp_busy_len", busy_cnt1, 16);
    check("clamp_and_fail_vec", fv1, 4'b0110);

    // Stuck at 0
    mode = 2;
    pulse_start(1);
    wait_done(200);
    check("stuck_fail_vec", fv0, 4'b1000);
    check("stuck_pass", pass0, 0);
    check("stuck_done", done0, 1);

    // OR model
    mode = 1;
    pulse_start(1);
    wait_done(200);
    check("or_fail_vec", fv0, 4'b0110);
    check("or_pass", pass0, 0);
    check("or_1110_pass", pass1, 1);
    check("or_1110_fail_vec", fv1, 4'b0000);

    // Reset during SETTLE of vector 2
    mode = 0;
    pulse_start(1);
    repeat (29) @(negedge clk);
    check("vec2_ab", {b0, a0}, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_reset", {busy0, done0, pass0, b0, a0, fv0}, 0);
    rst_n = 1'b1;
    busy_cnt0 = 0;
    pulse_start(1);
    wait_done(200);
    check("rerun_busy_len", busy_cnt0, 52);
    check("rerun_pass", pass0, 1);

    // START held high: back-to-back runs
    mode  = 0;
    dcnt  = 0;
    start = 1'b1;
    repeat (160) begin
      @(negedge clk);
      if (done0 === 1'b1) dcnt++;
    end
    check("held_done_cycles", dcnt, 3);
    start = 1'b0;
    wait_done(200);

    // Randomized runs
    repeat (8) begin
      mode = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_start(int'($urandom_range(1, 3)));
      wait_done(200);
    end
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
